// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register block for the DSP datapath.
// Holds the read-only CORE_ID and DATE words and three read/write control fields
// (fifo_en, sel_source, sel_fir). The datapath consumes the control fields as
// static levels.
//
// Optional feature: define AXI_REGS_SLVERR_EN to make unmapped accesses
// (word index 5..7) respond SLVERR. Without it, every access responds OKAY.
//
// Ports:
//   axi_clk, axi_rst         clock, asynchronous active-high reset
//   s_axi_aw*                write-address channel (only addr[4:2] decoded)
//   s_axi_w*                 write-data channel (control bits live in byte 0)
//   s_axi_b*                 write-response channel
//   s_axi_ar*                read-address channel (only addr[4:2] decoded)
//   s_axi_r*                 read-data channel
//   fifo_en, sel_source, sel_fir   registered control levels to the datapath
module axi_lite_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH   = 40,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] CORE_ID      = 32'h0000_0000,
  parameter logic [31:0] DATE         = 32'h0000_0000,
  parameter int unsigned SEL_SOURCE_W = 2,
  parameter int unsigned SEL_FIR_W    = 2
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      fifo_en,
  output logic [SEL_SOURCE_W-1:0]   sel_source,
  output logic [SEL_FIR_W-1:0]      sel_fir
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_CORE_ID    = 3'd0;
  localparam logic [2:0] IDX_DATE       = 3'd1;
  localparam logic [2:0] IDX_FIFO_EN    = 3'd2;
  localparam logic [2:0] IDX_SEL_SOURCE = 3'd3;
  localparam logic [2:0] IDX_SEL_FIR    = 3'd4;

`ifdef AXI_REGS_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  // Holding registers for an AW or W beat that arrived before its partner.
  logic [2:0] aw_idx_q;
  logic [7:0] w_byte_q;
  logic       w_strb0_q;

  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [2:0]            wr_idx;
  logic [7:0]            wr_byte;
  logic                  wr_strb0;
  logic [DATA_WIDTH-1:0] rd_word;

  // Only the decoded address bits and byte 0 of the write data carry meaning.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                         s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0],
                         s_axi_wdata[DATA_WIDTH-1:8], s_axi_wstrb[DATA_WIDTH/8-1:1],
                         wr_byte};

  function automatic logic [1:0] resp_for(input logic [2:0] idx);
    return (SLVERR_EN && (idx > IDX_SEL_FIR)) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Merge the held beat with the one arriving this cycle.
  assign wr_idx   = (wr_state == WR_HAVE_AW) ? aw_idx_q  : s_axi_awaddr[4:2];
  assign wr_byte  = (wr_state == WR_HAVE_W)  ? w_byte_q  : s_axi_wdata[7:0];
  assign wr_strb0 = (wr_state == WR_HAVE_W)  ? w_strb0_q : s_axi_wstrb[0];

  assign wr_fire = ((wr_state == WR_IDLE)    && aw_hs && w_hs) ||
                   ((wr_state == WR_HAVE_AW) && w_hs) ||
                   ((wr_state == WR_HAVE_W)  && aw_hs);

  // Read mux over current register contents (pre-write on a same-cycle write).
  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[4:2])
      IDX_CORE_ID:    rd_word = DATA_WIDTH'(CORE_ID);
      IDX_DATE:       rd_word = DATA_WIDTH'(DATE);
      IDX_FIFO_EN:    rd_word = DATA_WIDTH'(fifo_en);
      IDX_SEL_SOURCE: rd_word = DATA_WIDTH'(sel_source);
      IDX_SEL_FIR:    rd_word = DATA_WIDTH'(sel_fir);
      default:        rd_word = '0;
    endcase
  end

  // Write channel FSM and control registers.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_idx_q      <= '0;
      w_byte_q      <= '0;
      w_strb0_q     <= 1'b0;
      fifo_en       <= 1'b0;
      sel_source    <= '0;
      sel_fir       <= '0;
    end else begin
      case (wr_state)
        WR_IDLE, WR_HAVE_AW, WR_HAVE_W: begin
          if (aw_hs) aw_idx_q <= s_axi_awaddr[4:2];
          if (w_hs) begin
            w_byte_q  <= s_axi_wdata[7:0];
            w_strb0_q <= s_axi_wstrb[0];
          end
          if (wr_fire) begin
            // Control fields all sit in byte 0; other strobes have no effect.
            if (wr_strb0) begin
              case (wr_idx)
                IDX_FIFO_EN:    fifo_en    <= wr_byte[0];
                IDX_SEL_SOURCE: sel_source <= wr_byte[SEL_SOURCE_W-1:0];
                IDX_SEL_FIR:    sel_fir    <= wr_byte[SEL_FIR_W-1:0];
                default:        ;
              endcase
            end
            s_axi_bresp   <= resp_for(wr_idx);
            s_axi_bvalid  <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            wr_state      <= WR_RESP;
          end else if (aw_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_HAVE_AW;
          end else if (w_hs) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            wr_state      <= WR_HAVE_W;
          end else begin
            s_axi_awready <= (wr_state != WR_HAVE_AW);
            s_axi_wready  <= (wr_state != WR_HAVE_W);
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read channel FSM.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      rd_state      <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            s_axi_rdata   <= rd_word;
            s_axi_rresp   <= resp_for(s_axi_araddr[4:2]);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            rd_state      <= RD_RESP;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Self-checking bench for axi_lite_ctrl_regs: directed AXI-Lite transactions,
// a register-map model updated at transaction completion, and a per-cycle
// compare of the control outputs against that model.
module tb_axi_lite_ctrl_regs;

  localparam logic [31:0] CORE_ID_V = 32'hC0DE_0001;
  localparam logic [31:0] DATE_V    = 32'h2024_0601;
`ifdef AXI_REGS_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif
  localparam logic [1:0] UNMAPPED_RESP = SLV ? 2'b10 : 2'b00;

  logic        axi_clk = 1'b0;
  logic        axi_rst;
  logic [39:0] s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [39:0] s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        fifo_en;
  logic [1:0]  sel_source, sel_fir;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Register-map model
  logic       model_fifo;
  logic [1:0] model_src, model_fir;

  always #5 axi_clk = ~axi_clk;

  axi_lite_ctrl_regs #(
    .ADDR_WIDTH(40), .DATA_WIDTH(32), .CORE_ID(CORE_ID_V), .DATE(DATE_V),
    .SEL_SOURCE_W(2), .SEL_FIR_W(2)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .fifo_en(fifo_en), .sel_source(sel_source), .sel_fir(sel_fir)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [39:0] a);
    logic [2:0] idx;
    idx = a[4:2];
    case (idx)
      3'd0:    return CORE_ID_V;
      3'd1:    return DATE_V;
      3'd2:    return {31'b0, model_fifo};
      3'd3:    return {30'b0, model_src};
      3'd4:    return {30'b0, model_fir};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input logic [39:0] a);
    logic [2:0] idx;
    idx = a[4:2];
    return (SLV && idx > 3'd4) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [2:0] idx;
    idx = a[4:2];
    if (s[0]) begin
      case (idx)
        3'd2:    model_fifo = d[0];
        3'd3:    model_src  = d[1:0];
        3'd4:    model_fir  = d[1:0];
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    model_fifo = 1'b0;
    model_src  = 2'b00;
    model_fir  = 2'b00;
  endtask

  // Per-cycle comparison of the datapath levels against the model
  always @(negedge axi_clk) begin
    if (cmp_en && !axi_rst) begin
      chk("fifo_en_vs_model", 32'(fifo_en), 32'(model_fifo));
      chk("sel_source_vs_model", 32'(sel_source), 32'(model_src));
      chk("sel_fir_vs_model", 32'(sel_fir), 32'(model_fir));
      if (s_axi_bvalid) chk("awready_while_bvalid", 32'(s_axi_awready), 32'h0);
      if (s_axi_rvalid) chk("arready_while_rvalid", 32'(s_axi_arready), 32'h0);
    end
  end

  // AW issued at cycle aw_start, W at w_start; bready held low for b_hold cycles,
  // optionally presenting a second AW during that time.
  task automatic axi_write(input logic [39:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_start, input int w_start,
                           input int b_hold, input bit poke_aw);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    @(posedge axi_clk); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(aw_done && w_done)) begin
      s_axi_awvalid = !aw_done && cyc >= aw_start;
      s_axi_wvalid  = !w_done && cyc >= w_start;
      @(negedge axi_clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge axi_clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (aw_done && w_done) model_write(addr, data, strb);
      #1;
      cyc++;
      if (cyc > 40) begin
        chk("write_handshake_timeout", 32'h0, 32'h1);
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        return;
      end
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    s_axi_bready = 0;
    if (poke_aw) begin
      s_axi_awaddr = 40'h08;
      s_axi_awvalid = 1;
    end
    for (int i = 0; i < b_hold; i++) begin
      @(negedge axi_clk);
      chk("bvalid_held", 32'(s_axi_bvalid), 32'h1);
      chk("awready_blocked", 32'(s_axi_awready), 32'h0);
      chk("wready_blocked", 32'(s_axi_wready), 32'h0);
      chk("bresp_stable", 32'(s_axi_bresp), 32'(model_resp(addr)));
      @(posedge axi_clk); #1;
    end
    s_axi_awvalid = 0;
    s_axi_bready = 1;
    @(negedge axi_clk);
    chk("bvalid", 32'(s_axi_bvalid), 32'h1);
    chk("bresp", 32'(s_axi_bresp), 32'(model_resp(addr)));
    @(posedge axi_clk); #1;
    s_axi_bready = 0;
    @(negedge axi_clk);
    chk("bvalid_cleared", 32'(s_axi_bvalid), 32'h0);
    chk("awready_after_b", 32'(s_axi_awready), 32'h1);
    chk("wready_after_b", 32'(s_axi_wready), 32'h1);
  endtask

  task automatic axi_read(input logic [39:0] addr, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    cyc = 0; exp_d = '0; exp_r = '0;
    data = 'x; resp = 'x;
    @(posedge axi_clk); #1;
    s_axi_araddr = addr;
    s_axi_arvalid = 1;
    hs = 0;
    while (!hs) begin
      @(negedge axi_clk);
      hs = s_axi_arready;
      @(posedge axi_clk);
      if (hs) begin
        exp_d = model_read(addr);
        exp_r = model_resp(addr);
      end
      #1;
      cyc++;
      if (!hs && cyc > 40) begin
        chk("read_handshake_timeout", 32'h0, 32'h1);
        s_axi_arvalid = 0;
        return;
      end
    end
    s_axi_arvalid = 0;
    s_axi_rready = 0;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge axi_clk);
      chk("rvalid_held", 32'(s_axi_rvalid), 32'h1);
      chk("rdata_stable", s_axi_rdata, exp_d);
      @(posedge axi_clk); #1;
    end
    s_axi_rready = 1;
    @(negedge axi_clk);
    chk("rvalid", 32'(s_axi_rvalid), 32'h1);
    chk("rdata_vs_model", s_axi_rdata, exp_d);
    chk("rresp_vs_model", 32'(s_axi_rresp), 32'(exp_r));
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge axi_clk); #1;
    s_axi_rready = 0;
    @(negedge axi_clk);
    chk("rvalid_cleared", 32'(s_axi_rvalid), 32'h0);
    chk("arready_after_r", 32'(s_axi_arready), 32'h1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;

  initial begin
    axi_rst = 1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
    s_axi_rready = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_awready", 32'(s_axi_awready), 32'h0);
    chk("rst_wready", 32'(s_axi_wready), 32'h0);
    chk("rst_arready", 32'(s_axi_arready), 32'h0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'h0);
    chk("rst_outputs", 32'({fifo_en, sel_source, sel_fir}), 32'h0);
    @(posedge axi_clk); #1;
    axi_rst = 0;
    @(negedge axi_clk);
    chk("awready_before_first_edge", 32'(s_axi_awready), 32'h0);
    @(negedge axi_clk);
    chk("awready_after_release", 32'(s_axi_awready), 32'h1);
    chk("wready_after_release", 32'(s_axi_wready), 32'h1);
    chk("arready_after_release", 32'(s_axi_arready), 32'h1);
    cmp_en = 1;

    // ID registers
    axi_read(40'h00, 0, rd, rr);
    chk("core_id_literal", rd, 32'hC0DE_0001);
    chk("core_id_rresp", 32'(rr), 32'h0);
    axi_read(40'h04, 2, rd, rr);
    chk("date_literal", rd, 32'h2024_0601);

    // FIFO enable, AW two cycles ahead of W
    axi_write(40'h08, 32'h1, 4'b1111, 0, 2, 0, 0);
    chk("fifo_en_literal", 32'(fifo_en), 32'h1);
    axi_read(40'h08, 0, rd, rr);
    chk("fifo_en_readback", rd, 32'h0000_0001);

    // Byte strobes on SEL_SOURCE
    axi_write(40'h0C, 32'hFFFF_FFFF, 4'b1110, 0, 0, 0, 0);
    chk("sel_source_strb_masked", 32'(sel_source), 32'h0);
    axi_write(40'h0C, 32'hFFFF_FFFF, 4'b0001, 0, 0, 0, 0);
    chk("sel_source_literal", 32'(sel_source), 32'h3);
    axi_read(40'h0C, 0, rd, rr);
    chk("sel_source_readback", rd, 32'h0000_0003);

    // RO write ignored, OKAY
    axi_write(40'h00, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 0);
    axi_read(40'h00, 0, rd, rr);
    chk("core_id_after_ro_write", rd, 32'hC0DE_0001);

    // Unmapped access
    axi_read(40'h14, 0, rd, rr);
    chk("unmapped_rdata", rd, 32'h0);
    chk("unmapped_rresp", 32'(rr), 32'(UNMAPPED_RESP));
    axi_write(40'h18, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 0);
    chk("unmapped_write_no_change", 32'({fifo_en, sel_source, sel_fir}), 32'b1_11_00);

    // SEL_FIR with W leading AW and a stalled B channel
    axi_write(40'h10, 32'h2, 4'b0001, 1, 0, 10, 1);
    chk("sel_fir_literal", 32'(sel_fir), 32'h2);

    // Reset while a read response is pending
    @(posedge axi_clk); #1;
    s_axi_araddr = 40'h10;
    s_axi_arvalid = 1;
    @(negedge axi_clk);
    chk("arready_before_rst", 32'(s_axi_arready), 32'h1);
    @(posedge axi_clk); #1;
    s_axi_arvalid = 0;
    @(negedge axi_clk);
    chk("rvalid_before_rst", 32'(s_axi_rvalid), 32'h1);
    chk("rdata_before_rst", s_axi_rdata, 32'h2);
    #1;
    axi_rst = 1;
    model_reset();
    #1;
    chk("async_rst_rvalid", 32'(s_axi_rvalid), 32'h0);
    chk("async_rst_sel_fir", 32'(sel_fir), 32'h0);
    chk("async_rst_outputs", 32'({fifo_en, sel_source}), 32'h0);
    chk("async_rst_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
    @(posedge axi_clk); #1;
    axi_rst = 0;
    axi_read(40'h10, 0, rd, rr);
    chk("sel_fir_after_rst", rd, 32'h0);

    repeat (2) @(posedge axi_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
